// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed 7-segment display: waits for each digit's pattern to
// settle, decodes it to hex and publishes a complete frame once every digit is seen.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    frame_valid,
    output logic                    err_invalid,
    output logic                    err_multi
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

    state_t                      state;
    logic [6:0]                  seg_q, cur_seg;
    logic [NUM_DIGITS-1:0]       en_q, mask, shadow_blank;
    logic [NUM_DIGITS-1:0][3:0]  shadow;
    logic [IDX_W-1:0]            idx, cur_idx;
    logic [CNT_W-1:0]            cnt, cnt_inc, cnt_next;
    logic                        en_any, en_multi, one_hot, same, start, cont, capture;
    logic                        glyph_ok, glyph_blank;
    logic [3:0]                  glyph_val;

    // Everything downstream of the sample register is active-high.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            seg_q <= '0;
            en_q  <= '0;
        end else begin
            seg_q <= (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
            en_q  <= (EN_ACTIVE_LOW != 0) ? ~en_in : en_in;
        end
    end

    always_comb begin
        idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (en_q[i]) idx = IDX_W'(i);
    end

    assign en_any   = |en_q;
    assign en_multi = (en_q & (en_q - NUM_DIGITS'(1))) != '0;
    assign one_hot  = en_any && !en_multi;
    assign same     = (idx == cur_idx) && (seg_q == cur_seg);
    // A new dwell starts from IDLE or whenever the held/dwelling sample changes.
    assign start    = one_hot && ((state == IDLE) || !same);
    assign cont     = one_hot && (state == DWELL) && same;
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign cnt_next = start ? CNT_W'(1) : cnt_inc;
    assign capture  = (start || cont) && (cnt_next == CNT_MAX);

    always_comb begin
        glyph_ok    = 1'b1;
        glyph_blank = 1'b0;
        glyph_val   = 4'h0;
        case (seg_q)
            7'h3F: glyph_val = 4'h0;
            7'h06: glyph_val = 4'h1;
            7'h5B: glyph_val = 4'h2;
            7'h4F: glyph_val = 4'h3;
            7'h66: glyph_val = 4'h4;
            7'h6D: glyph_val = 4'h5;
            7'h7D: glyph_val = 4'h6;
            7'h07: glyph_val = 4'h7;
            7'h7F: glyph_val = 4'h8;
            7'h6F: glyph_val = 4'h9;
            7'h77: glyph_val = 4'hA;
            7'h7C: glyph_val = 4'hB;
            7'h39: glyph_val = 4'hC;
            7'h5E: glyph_val = 4'hD;
            7'h79: glyph_val = 4'hE;
            7'h71: glyph_val = 4'hF;
            7'h00: glyph_blank = 1'b1;
            default: glyph_ok = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cur_idx      <= '0;
            cur_seg      <= '0;
            mask         <= '0;
            shadow       <= '0;
            shadow_blank <= '1;
            digits_out   <= '0;
            blank_out    <= '1;
            frame_valid  <= 1'b0;
            err_invalid  <= 1'b0;
            err_multi    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            err_invalid <= 1'b0;
            err_multi   <= 1'b0;

            if (!en_any) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (en_multi) begin
                err_multi <= 1'b1;
                state     <= IDLE;
                cnt       <= '0;
            end else if (!(state == HELD && same)) begin
                cnt     <= cnt_next;
                cur_idx <= idx;
                cur_seg <= seg_q;
                state   <= capture ? HELD : DWELL;
            end

            // en_q is one-hot whenever capture is high, so it doubles as the mask bit.
            mask <= ((&mask) ? '0 : mask) | ((capture && glyph_ok) ? en_q : '0);
            if (&mask) begin
                digits_out  <= shadow;
                blank_out   <= shadow_blank;
                frame_valid <= 1'b1;
            end

            if (capture) begin
                if (glyph_ok) begin
                    shadow[idx]       <= glyph_val;
                    shadow_blank[idx] <= glyph_blank;
                end else begin
                    err_invalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with default parameters (active-low seg/en, 4-sample dwell).
module tb_seg7_scan_decoder;

    logic        Clk, Reset;
    logic [6:0]  seg_in;
    logic [7:0]  en_in;
    logic [31:0] digits_out;
    logic [7:0]  blank_out;
    logic        frame_valid, err_invalid, err_multi;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_cnt  = 0;
    int ei_cnt  = 0;
    int em_cnt  = 0;

    seg7_scan_decoder dut (
        .Clk(Clk), .Reset(Reset), .seg_in(seg_in), .en_in(en_in),
        .digits_out(digits_out), .blank_out(blank_out), .frame_valid(frame_valid),
        .err_invalid(err_invalid), .err_multi(err_multi)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pulse tally, sampled shortly after each rising edge.
    always @(posedge Clk) begin
        #2;
        if (frame_valid) fv_cnt = fv_cnt + 1;
        if (err_invalid) ei_cnt = ei_cnt + 1;
        if (err_multi)   em_cnt = em_cnt + 1;
    end

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on a falling edge and are held for n cycles.
    task automatic apply(input logic [7:0] en, input logic [6:0] seg, input int n);
        en_in  = en;
        seg_in = seg;
        repeat (n) @(negedge Clk);
    endtask

    task automatic show(input int d, input int v, input int n);
        logic [7:0] one;
        logic [6:0] g;
        one = 8'h01 << d;
        g   = glyph(v);
        apply(~one, ~g, n);
    endtask

    initial begin
        Reset  = 1'b0;
        en_in  = 8'hFF;
        seg_in = 7'h7F;
        @(negedge Clk);

        // T1: reset with random inputs, then release
        for (int k = 0; k < 4; k++) apply(8'($urandom), 7'($urandom), 1);
        check("t1_digits", digits_out, 32'h0);
        check("t1_blank", {24'h0, blank_out}, 32'hFF);
        check("t1_pulses", {29'h0, frame_valid, err_invalid, err_multi}, 32'h0);
        Reset = 1'b1;
        apply(8'hFF, 7'h7F, 4);
        check("t1_rel_digits", digits_out, 32'h0);
        check("t1_rel_blank", {24'h0, blank_out}, 32'hFF);
        check("t1_rel_fv", fv_cnt, 0);

        // T2: clean scan 0..7, frame one cycle after digit 7's 4th stable sample
        for (int d = 0; d < 7; d++) show(d, d, 6);
        show(7, 7, 5);
        check("t2_fv_early", {31'h0, frame_valid}, 32'h0);
        check("t2_fv_cnt_early", fv_cnt, 0);
        show(7, 7, 1);
        check("t2_fv_latency", {31'h0, frame_valid}, 32'h1);
        check("t2_digits", digits_out, 32'h76543210);
        check("t2_blank", {24'h0, blank_out}, 32'h0);
        apply(8'hFF, 7'h7F, 3);
        check("t2_fv_cnt", fv_cnt, 1);
        check("t2_errs", ei_cnt + em_cnt, 0);

        // T3: glitch on digit 2 (2 for 2 cycles, then 5)
        show(0, 8, 6); show(1, 9, 6);
        show(2, 2, 2); show(2, 5, 4);
        show(3, 10, 6); show(4, 11, 6); show(5, 12, 6); show(6, 13, 6); show(7, 15, 6);
        apply(8'hFF, 7'h7F, 3);
        check("t3_fv_cnt", fv_cnt, 2);
        check("t3_digits", digits_out, 32'hFDCBA598);
        check("t3_errs", ei_cnt + em_cnt, 0);

        // T4: blank digit 3, invalid pattern on digit 4, then multi-enable
        show(0, 1, 6); show(1, 2, 6); show(2, 3, 6);
        apply(8'hF7, 7'h7F, 4);
        apply(8'hEF, 7'h55, 6);
        check("t4_err_invalid", ei_cnt, 1);
        show(5, 5, 6); show(6, 6, 6); show(7, 7, 6);
        check("t4_no_frame_wo_d4", fv_cnt, 2);
        show(4, 4, 6);
        apply(8'hFF, 7'h7F, 3);
        check("t4_fv_cnt", fv_cnt, 3);
        check("t4_digits", digits_out, 32'h76540321);
        check("t4_blank", {24'h0, blank_out}, 32'h08);
        apply(8'hFC, 7'h40, 3);
        apply(8'hFF, 7'h7F, 3);
        check("t4_err_multi", em_cnt, 3);
        check("t4_ei_total", ei_cnt, 1);

        // T5: reset mid-frame discards partial captures
        for (int d = 0; d < 5; d++) show(d, 3, 6);
        Reset = 1'b0;
        apply(8'hFF, 7'h7F, 2);
        check("t5_rst_digits", digits_out, 32'h0);
        check("t5_rst_blank", {24'h0, blank_out}, 32'hFF);
        Reset = 1'b1;
        apply(8'hFF, 7'h7F, 2);
        show(5, 10, 6); show(6, 9, 6); show(7, 8, 6);
        apply(8'hFF, 7'h7F, 3);
        check("t5_no_stale_frame", fv_cnt, 3);
        show(0, 15, 6); show(1, 14, 6); show(2, 13, 6); show(3, 12, 6); show(4, 11, 6);
        apply(8'hFF, 7'h7F, 3);
        check("t5_fv_cnt", fv_cnt, 4);
        check("t5_digits", digits_out, 32'h89ABCDEF);
        check("t5_blank", {24'h0, blank_out}, 32'h0);

        // T6: digit 1 re-captured (9 then A) before the frame completes
        show(0, 1, 6); show(1, 9, 6); show(1, 10, 6);
        for (int d = 2; d < 8; d++) show(d, d, 6);
        apply(8'hFF, 7'h7F, 3);
        check("t6_fv_cnt", fv_cnt, 5);
        check("t6_digits", digits_out, 32'h765432A1);
        check("t6_errs", ei_cnt * 16 + em_cnt, 32'h13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
